// File: rtl/dsp_p_out_stage.sv
// Result-side output stage of the DSP48A1 slice: 2-entry skid buffer for P/CARRYOUT.
// Optional pattern-detect compare enabled by defining P_OUT_PATTERN_DETECT_EN.
module dsp_p_out_stage #(
    parameter int unsigned    N       = 48,
    parameter logic [N-1:0]   PATTERN = '0,
    parameter logic [N-1:0]   MASK    = N'(48'h3FFF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CE,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] P_in,
    input  logic         CARRYOUT_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] P_out,
    output logic         CARRYOUT_out,
    output logic         PATTERNDETECT,
    output logic [1:0]   occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic         pd;
        logic         carry;
        logic [N-1:0] p;
    } entry_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   pd_in;
    logic   push;
    logic   pop;

`ifdef P_OUT_PATTERN_DETECT_EN
    // Match when every unmasked bit of P equals the pattern.
    assign pd_in = (((P_in ^ PATTERN) & ~MASK) == '0);
`else
    assign pd_in = 1'b0;
`endif

    assign in_entry  = '{pd: pd_in, carry: CARRYOUT_in, p: P_in};

    assign in_ready  = rst & CE & (state != FULL);
    assign out_valid = rst & CE & (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer state and storage; reset outranks CE and any handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (CE) begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= in_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= in_entry;
                    end else if (push) begin
                        skid  <= in_entry;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign P_out         = head.p;
    assign CARRYOUT_out  = head.carry;
    assign PATTERNDETECT = head.pd;
    assign occupancy     = state;

endmodule

// File: tb/tb_dsp_p_out_stage.sv
// Self-checking bench for dsp_p_out_stage: directed scenarios plus random traffic
// compared every cycle against a queue-based FIFO reference model.
module tb_dsp_p_out_stage;

    localparam int unsigned N = 48;
    localparam logic [N-1:0] PAT = '0;
    localparam logic [N-1:0] MSK = 48'h3FFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] p_in;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] p_out;
    logic         carry_out;
    logic         pattern_detect;
    logic [1:0]   occupancy;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Reference model: entries are {pd, carry, P}; last is what head shows when empty.
    logic [N+1:0] q[$];
    logic [N+1:0] last = '0;

    always #5 clk = ~clk;

    dsp_p_out_stage #(.N(N), .PATTERN(PAT), .MASK(MSK)) dut (
        .clk          (clk),
        .rst          (rst),
        .CE           (ce),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .P_in         (p_in),
        .CARRYOUT_in  (carry_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .P_out        (p_out),
        .CARRYOUT_out (carry_out),
        .PATTERNDETECT(pattern_detect),
        .occupancy    (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic model_pd(input logic [N-1:0] p);
`ifdef P_OUT_PATTERN_DETECT_EN
        return ((p & ~MSK) == (PAT & ~MSK));
`else
        return 1'b0;
`endif
    endfunction

    // Compare outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        logic         exp_ir;
        logic         exp_ov;
        logic [N+1:0] hd;
        logic         do_push;
        logic         do_pop;
        if (chk_en) begin
            exp_ir = rst && ce && (q.size() != 2);
            exp_ov = rst && ce && (q.size() != 0);
            hd     = (q.size() != 0) ? q[0] : last;
            check("in_ready",      64'(in_ready),       64'(exp_ir));
            check("out_valid",     64'(out_valid),      64'(exp_ov));
            check("P_out",         64'(p_out),          64'(hd[N-1:0]));
            check("CARRYOUT_out",  64'(carry_out),      64'(hd[N]));
            check("PATTERNDETECT", 64'(pattern_detect), 64'(hd[N+1]));
            check("occupancy",     64'(occupancy),      64'(q.size()));
            if (!rst) begin
                q.delete();
                last = '0;
            end else if (ce) begin
                do_push = in_valid && exp_ir;
                do_pop  = exp_ov && out_ready;
                if (do_pop) last = q.pop_front();
                if (do_push) q.push_back({model_pd(p_in), carry_in, p_in});
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic v,
                         input logic [N-1:0] d, input logic co, input logic o);
        rst       = r;
        ce        = e;
        in_valid  = v;
        p_in      = d;
        carry_in  = co;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1; in_valid = 1'b1; p_in = 48'h123; carry_in = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset hold with upstream pushing
        drive(0, 1, 1, 48'h123, 1, 1);
        drive(0, 1, 1, 48'h123, 1, 1);
        drive(0, 1, 1, 48'h123, 1, 1);

        // Streaming 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) drive(1, 1, 1, N'(i), 1'(i), 1);
        drive(1, 1, 0, '0, 0, 1);
        drive(1, 1, 0, '0, 0, 1);

        // Backpressure then release
        drive(1, 1, 1, 48'hA, 1, 0);
        drive(1, 1, 1, 48'hB, 0, 0);
        drive(1, 1, 1, 48'hC, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, '0, 0, 1);

        // CE freeze while full
        drive(1, 1, 1, 48'hA5, 0, 0);
        drive(1, 1, 1, 48'hA6, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 48'hEE, 1, 1);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, '0, 0, 1);

        // Mid-operation reset discards buffered entries
        drive(1, 1, 1, 48'h51, 1, 0);
        drive(1, 1, 1, 48'h52, 1, 0);
        drive(0, 1, 1, 48'h53, 1, 1);
        drive(1, 1, 0, '0, 0, 1);
        drive(1, 1, 0, '0, 0, 1);

        // Pattern-detect boundary values, routed through the skid path too
        drive(1, 1, 1, 48'h0000_0000_1234, 0, 0);
        drive(1, 1, 1, 48'h0000_0001_0000, 1, 0);
        drive(1, 1, 1, 48'h0000_0000_3FFF, 0, 1);
        drive(1, 1, 1, 48'h0000_0000_4000, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, '0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] d;
            d = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 0) d = d & MSK;
            drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 70), d, 1'($urandom()),
                  ($urandom_range(0, 99) < 60));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
